keccak_rhopi_pipe: RTL

Registered, handshaked rho∘pi stage for a masked Keccak-f state of SHARES shares and lane width W. Both permutation directions are supported: forward for the permutation, inverse for the inverse round path. Each share is permuted independently, since the step is linear and needs no cross-share mixing. The block sits between theta and the DOM chi stage. A 2-entry output buffer provides valid/ready back-pressure without a combinational ready path.

---
 rtl/keccak_rhopi_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/keccak_rhopi_pipe.sv
// -----------------------------------------------------------------------------
// keccak_rhopi_pipe
//
// Registered, handshaked rho-then-pi stage for a masked Keccak-f state. It
// sits between theta and the DOM chi stage. Every share is permuted
// independently with the same wiring, because the step is linear. A
// 2-entry output FIFO gives back-pressure without a combinational path
// from OutReadyxSI to InReadyxSO.
//
// Parameters
//   W       lane width, a power of two in 1..64
//   SHARES  number of Boolean shares (>= 1)
//
// Ports
//   ClkxCI       in   clock, rising edge
//   RstxRBI      in   asynchronous active-low reset
//   FlushxSI     in   synchronous clear of the buffer; overrides push/pop
//   InValidxSI   in   input state valid
//   InReadyxSO   out  buffer can accept (count != 2), from registers only
//   ModexSI      in   0 = forward rho then pi, 1 = inverse pi^-1 then rho^-1
//   StatexDI     in   share s at bits [s*25*W +: 25*W], lane (x,y) at (5x+y)*W
//   OutValidxSO  out  head entry valid (count != 0)
//   OutReadyxSI  in   downstream accepts the head entry
//   ModexSO      out  mode of the head entry, 0 when empty
//   StatexDO     out  permuted head entry, 0 when empty
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on that side. Valid does not wait for ready. Push is
// InValidxSI & InReadyxSO. Pop is OutValidxSO & OutReadyxSI.
// -----------------------------------------------------------------------------
module keccak_rhopi_pipe #(
    parameter int W      = 16,
    parameter int SHARES = 2
) (
    input  logic                   ClkxCI,
    input  logic                   RstxRBI,
    input  logic                   FlushxSI,
    input  logic                   InValidxSI,
    output logic                   InReadyxSO,
    input  logic                   ModexSI,
    input  logic [SHARES*25*W-1:0] StatexDI,
    output logic                   OutValidxSO,
    input  logic                   OutReadyxSI,
    output logic                   ModexSO,
    output logic [SHARES*25*W-1:0] StatexDO
);

    localparam int SW = SHARES * 25 * W;

    // Keccak rho offsets, indexed by 5x+y.
    function automatic int rho_off(input int idx);
        case (idx)
            0:  rho_off = 0;
            1:  rho_off = 36;
            2:  rho_off = 3;
            3:  rho_off = 41;
            4:  rho_off = 18;
            5:  rho_off = 1;
            6:  rho_off = 44;
            7:  rho_off = 10;
            8:  rho_off = 45;
            9:  rho_off = 2;
            10: rho_off = 62;
            11: rho_off = 6;
            12: rho_off = 43;
            13: rho_off = 15;
            14: rho_off = 61;
            15: rho_off = 28;
            16: rho_off = 55;
            17: rho_off = 25;
            18: rho_off = 21;
            19: rho_off = 56;
            20: rho_off = 27;
            21: rho_off = 20;
            22: rho_off = 39;
            23: rho_off = 8;
            24: rho_off = 14;
            default: rho_off = 0;
        endcase
    endfunction

    logic [SW-1:0] w_fwd;
    logic [SW-1:0] w_inv;
    logic [SW-1:0] w_perm;

    // Pure wiring. Source lane (x,y) maps to destination lane (y, 2x+3y mod 5).
    // A lane is doubled so that a constant rotation becomes a plain slice:
    // slice [W-r +: W] rotates left by r, and slice [r +: W] rotates right by r.
    for (genvar s = 0; s < SHARES; s++) begin : g_share
        for (genvar x = 0; x < 5; x++) begin : g_x
            for (genvar y = 0; y < 5; y++) begin : g_y
                localparam int IDX = 5 * x + y;
                localparam int DST = 5 * y + ((2 * x + 3 * y) % 5);
                localparam int ROT = rho_off(IDX) % W;
                localparam int BS  = s * 25 * W;

                logic [2*W-1:0] w_fwd_dbl;
                logic [2*W-1:0] w_inv_dbl;

                assign w_fwd_dbl = {2{StatexDI[BS + IDX*W +: W]}};
                assign w_fwd[BS + DST*W +: W] = w_fwd_dbl[W-ROT +: W];

                assign w_inv_dbl = {2{StatexDI[BS + DST*W +: W]}};
                assign w_inv[BS + IDX*W +: W] = w_inv_dbl[ROT +: W];
            end
        end
    end

    assign w_perm = ModexSI ? w_inv : w_fwd;

    // Output FIFO
    logic [SW-1:0] r_mem [2];
    logic [1:0]    r_mode;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign InReadyxSO  = (r_count != 2'd2);
    assign OutValidxSO = (r_count != 2'd0);
    assign w_push      = InValidxSI & InReadyxSO;
    assign w_pop       = OutValidxSO & OutReadyxSI;

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else if (FlushxSI) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is never read unless the count says it is valid, so it
    // is left out of reset.
    always_ff @(posedge ClkxCI) begin
        if (w_push && !FlushxSI) begin
            r_mem[r_wptr]  <= w_perm;
            r_mode[r_wptr] <= ModexSI;
        end
    end

    // The head is gated by the count, so an asynchronous reset zeroes the
    // outputs at once.
    assign StatexDO = OutValidxSO ? r_mem[r_rptr] : '0;
    assign ModexSO  = OutValidxSO ? r_mode[r_rptr] : 1'b0;

endmodule
